// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: widths, control-bundle bit map and bubble value.
package mips_pipe_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CTRL_WIDTH = 9;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP    = 0;
  localparam int ALUOP_W       = 3;

  localparam logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check of the decode instruction against the load in EX.
// Branch flush overrides: a wrong-path instruction is dropped, not stalled.
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic     id_valid,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_alu_src,
  input  logic     id_mem_write,
  input  logic     ex_valid,
  input  logic     ex_mem_read,
  input  reg_idx_t ex_dest,
  input  logic     flush,
  output logic     stall
);

  logic uses_rt;
  logic rs_hit;
  logic rt_hit;
  logic hazard;

  // stores read rt as data even though aluSrc selects the immediate
  assign uses_rt = ~id_alu_src | id_mem_write;
  assign rs_hit  = (ex_dest == id_rs);
  assign rt_hit  = uses_rt & (ex_dest == id_rt);

  assign hazard = id_valid & ex_valid & ex_mem_read &
                  (ex_dest != 5'd0) & (rs_hit | rt_hit);

  assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// and saturating stall/flush performance counters.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_r1,
  input  logic [DATA_W-1:0] id_r2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_r1,
  output logic [DATA_W-1:0] ex_r2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [4:0] id_dest;

  assign id_dest = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;

  hazard_detect u_hazard (
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_alu_src   (id_ctrl[CTRL_ALUSRC]),
    .id_mem_write (id_ctrl[CTRL_MEMWRITE]),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl[CTRL_MEMREAD]),
    .ex_dest      (ex_dest),
    .flush        (flush),
    .stall        (stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_r1     <= '0;
      ex_r2     <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
      ex_ctrl   <= CTRL_W'(CTRL_BUBBLE);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush || stall) begin
      ex_valid <= 1'b0;
      ex_r1    <= '0;
      ex_r2    <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dest  <= '0;
      ex_ctrl  <= CTRL_W'(CTRL_BUBBLE);
      // stall is already masked by flush, so at most one counter moves
      if (flush && id_valid && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end else begin
      ex_valid <= id_valid;
      ex_r1    <= id_r1;
      ex_r2    <= id_r2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_dest  <= id_dest;
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_W'(CTRL_BUBBLE);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

  localparam int DW = 8;
  localparam int CW = 9;
  localparam int NW = 8;
  localparam int MAXC = (1 << NW) - 1;

  localparam logic [CW-1:0] C_LW   = 9'b110110000;
  localparam logic [CW-1:0] C_ADD  = 9'b100001010;
  localparam logic [CW-1:0] C_ADDI = 9'b100010000;
  localparam logic [CW-1:0] C_SW   = 9'b001010000;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_r1, id_r2, id_imm;
  logic [CW-1:0] id_ctrl;
  logic flush;
  logic stall;
  logic ex_valid;
  logic [DW-1:0] ex_r1, ex_r2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_dest;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int passed = 0;

  logic m_valid;
  logic [DW-1:0] m_r1, m_r2, m_imm;
  logic [4:0] m_rs, m_rt, m_dest;
  logic [CW-1:0] m_ctrl;
  int m_sc, m_fc;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_r1(ex_r1), .ex_r2(ex_r2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit model_stall();
    bit reads_rt;
    bit hit;
    reads_rt = !id_ctrl[4] || id_ctrl[6];
    hit = (m_dest == id_rs) || (reads_rt && m_dest == id_rt);
    return id_valid && m_valid && m_ctrl[7] && m_dest != 0 && hit
           && !flush;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0;
  endtask

  task automatic model_step();
    bit s;
    if (rst) begin
      model_clear();
      m_sc = 0; m_fc = 0;
      return;
    end
    s = model_stall();
    if (flush) begin
      model_clear();
      if (id_valid && m_fc < MAXC) m_fc++;
    end else if (s) begin
      model_clear();
      if (m_sc < MAXC) m_sc++;
    end else begin
      m_valid = id_valid;
      m_r1 = id_r1; m_r2 = id_r2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt;
      m_dest = id_ctrl[3] ? id_rd : id_rt;
      m_ctrl = id_valid ? id_ctrl : '0;
    end
  endtask

  task automatic check_all();
    chk("stall", int'(stall), int'(model_stall()));
    chk("ex_valid", int'(ex_valid), int'(m_valid));
    chk("ex_r1", int'(ex_r1), int'(m_r1));
    chk("ex_r2", int'(ex_r2), int'(m_r2));
    chk("ex_imm", int'(ex_imm), int'(m_imm));
    chk("ex_rs", int'(ex_rs), int'(m_rs));
    chk("ex_rt", int'(ex_rt), int'(m_rt));
    chk("ex_dest", int'(ex_dest), int'(m_dest));
    chk("ex_ctrl", int'(ex_ctrl), int'(m_ctrl));
    chk("stall_cnt", int'(stall_cnt), m_sc);
    chk("flush_cnt", int'(flush_cnt), m_fc);
  endtask

  task automatic drive(input logic v, input int rs, input int rt,
                       input int rd, input int r1, input int r2,
                       input int imm, input logic [CW-1:0] c,
                       input logic fl);
    id_valid = v;
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_r1 = DW'(r1); id_r2 = DW'(r2); id_imm = DW'(imm);
    id_ctrl = c; flush = fl;
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, '0, 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    m_sc = 0; m_fc = 0;
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_valid", int'(ex_valid), 0);
    chk("reset_scnt", int'(stall_cnt), 0);

    // reset asserted in the middle of a stall cycle
    drive(1, 0, 3, 0, 1, 2, 3, C_LW, 0);
    cycle();
    drive(1, 3, 4, 6, 9, 9, 0, C_ADD, 0);
    #1 chk("t1_stall_before", int'(stall), 1);
    rst = 1'b1;
    #1;
    chk("t1_stall_rst", int'(stall), 0);
    chk("t1_ctrl_rst", int'(ex_ctrl), 0);
    chk("t1_dest_rst", int'(ex_dest), 0);
    model_step();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // lw $5 ; add $6,$5,$2
    drive(1, 1, 5, 0, 8'h11, 8'h22, 4, C_LW, 0);
    cycle();
    chk("t2_lw_dest", int'(ex_dest), 5);
    drive(1, 5, 2, 6, 8'h33, 8'h44, 0, C_ADD, 0);
    #1 chk("t2_stall", int'(stall), 1);
    cycle();
    chk("t2_bubble_v", int'(ex_valid), 0);
    chk("t2_bubble_c", int'(ex_ctrl), 0);
    chk("t2_scnt", int'(stall_cnt), 1);
    cycle();
    chk("t2_add_ctrl", int'(ex_ctrl), int'(C_ADD));
    chk("t2_add_dest", int'(ex_dest), 6);

    // addi with rt=5 does not read rt; sw does
    drive(1, 1, 5, 0, 0, 0, 0, C_LW, 0);
    cycle();
    drive(1, 4, 5, 7, 0, 0, 8'h7F, C_ADDI, 0);
    #1 chk("t3_addi_nostall", int'(stall), 0);
    drive(1, 4, 5, 0, 0, 0, 0, C_SW, 0);
    #1 chk("t3_sw_stall", int'(stall), 1);
    cycle();

    // $0 is never a hazard
    drive(1, 1, 0, 0, 0, 0, 0, C_LW, 0);
    cycle();
    drive(1, 0, 0, 8, 0, 0, 0, C_ADD, 0);
    #1 chk("t4_zero_nostall", int'(stall), 0);
    cycle();
    chk("t4_captured", int'(ex_valid), 1);

    // hazard coinciding with flush
    do_reset();
    drive(1, 1, 5, 0, 0, 0, 0, C_LW, 0);
    cycle();
    drive(1, 5, 2, 6, 0, 0, 0, C_ADD, 1);
    #1 chk("t5_stall", int'(stall), 0);
    cycle();
    chk("t5_bubble", int'(ex_valid), 0);
    chk("t5_fcnt", int'(flush_cnt), 1);
    chk("t5_scnt", int'(stall_cnt), 0);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [CW-1:0] c;
      c = CW'($urandom);
      if ($urandom_range(0, 2) == 0) c = C_LW;
      drive($urandom_range(0, 9) < 8,
            $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 6), $urandom, $urandom, $urandom,
            c, $urandom_range(0, 9) == 0);
      cycle();
    end

    // counter saturation
    do_reset();
    for (int i = 0; i < MAXC + 3; i++) begin
      drive(1, 1, 5, 0, 0, 0, 0, C_LW, 0);
      cycle();
      drive(1, 5, 2, 6, 0, 0, 0, C_ADD, 0);
      cycle();
    end
    chk("t6_scnt_sat", int'(stall_cnt), MAXC);
    drive(1, 1, 2, 3, 8'hA5, 8'h5A, 8'h0F, C_ADD, 0);
    cycle();
    chk("t6_r1", int'(ex_r1), 8'hA5);
    chk("t6_r2", int'(ex_r2), 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
